// File: rtl/c2_line_master_if.sv
// Request/response handshake between the cache controller and c2_line_master.
// resp_error exists only when C2_TIMEOUT_EN is defined.
interface c2_line_master_if #(
  parameter int unsigned ADDR_SIZE       = 15,
  parameter int unsigned CACHE_LINE_SIZE = 16
);
  localparam int unsigned LINE_W = CACHE_LINE_SIZE * 8;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [LINE_W-1:0]    req_wdata;
  logic                 resp_valid;
  logic [LINE_W-1:0]    resp_rdata;

`ifdef C2_TIMEOUT_EN
  logic                 resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
`endif
endinterface

// File: rtl/c2_line_master.sv
// Initiator of the C2 line-transfer bus: issues READ/WRITE for one cache line and moves it in beats.
// Optional WAIT-state timeout with resp_error is built when C2_TIMEOUT_EN is defined.
module c2_line_master #(
  parameter int unsigned ADDR_SIZE       = 15,
  parameter int unsigned BUS_SIZE        = 16,
  parameter int unsigned CACHE_LINE_SIZE = 16
`ifdef C2_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  c2_line_master_if.slave      req_if,
  output logic [ADDR_SIZE-1:0] mem_address,
  inout  wire  [BUS_SIZE-1:0]  mem_data,
  inout  wire  [1:0]           mem_command
);

  localparam int unsigned LINE_W = CACHE_LINE_SIZE * 8;
  localparam int unsigned BEATS  = LINE_W / BUS_SIZE;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef C2_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

  localparam logic [1:0] CMD_NOP      = 2'd0;
  localparam logic [1:0] CMD_RESPONSE = 2'd1;
  localparam logic [1:0] CMD_READ     = 2'd2;
  localparam logic [1:0] CMD_WRITE    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_e;

  state_e               state_q,   state_d;
  logic                 write_q,   write_d;
  logic [ADDR_SIZE-1:0] addr_q,    addr_d;
  logic [LINE_W-1:0]    wdata_q,   wdata_d;
  logic [LINE_W-1:0]    rdata_q,   rdata_d;
  logic [BEAT_W-1:0]    beat_q,    beat_d;
  logic                 ready_q,   ready_d;
  logic                 valid_q,   valid_d;
  logic                 cmd_oe_q,  cmd_oe_d;
  logic [1:0]           cmd_q,     cmd_d;
  logic                 data_oe_q, data_oe_d;
  logic [BUS_SIZE-1:0]  data_q,    data_d;
`ifdef C2_TIMEOUT_EN
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 error_q,    error_d;
`endif

  logic [BEAT_W-1:0]    next_beat;

  assign next_beat = BEAT_W'(beat_q + 1'b1);

  // Bus drivers come straight from reset-cleared enables, so reset releases them at once.
  assign mem_command = cmd_oe_q  ? cmd_q  : 'z;
  assign mem_data    = data_oe_q ? data_q : 'z;
  assign mem_address = addr_q;

  assign req_if.req_ready  = ready_q;
  assign req_if.resp_valid = valid_q;
  assign req_if.resp_rdata = rdata_q;
`ifdef C2_TIMEOUT_EN
  assign req_if.resp_error = error_q;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      beat_q     <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      cmd_oe_q   <= 1'b0;
      cmd_q      <= CMD_NOP;
      data_oe_q  <= 1'b0;
      data_q     <= '0;
`ifdef C2_TIMEOUT_EN
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      beat_q     <= beat_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      cmd_oe_q   <= cmd_oe_d;
      cmd_q      <= cmd_d;
      data_oe_q  <= data_oe_d;
      data_q     <= data_d;
`ifdef C2_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
`endif
    end
  end

  // Next-state, bus-drive and capture logic.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    beat_d     = beat_q;
    ready_d    = ready_q;
    valid_d    = 1'b0;
    cmd_oe_d   = 1'b0;
    cmd_d      = cmd_q;
    data_oe_d  = data_oe_q;
    data_d     = data_q;
`ifdef C2_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_if.req_valid && ready_q) begin
          write_d   = req_if.req_write;
          addr_d    = req_if.req_addr;
          wdata_d   = req_if.req_wdata;
          beat_d    = '0;
          ready_d   = 1'b0;
          cmd_oe_d  = 1'b1;
          cmd_d     = req_if.req_write ? CMD_WRITE : CMD_READ;
          data_oe_d = req_if.req_write;
          data_d    = req_if.req_wdata[BUS_SIZE-1:0];
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef C2_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_command == CMD_RESPONSE) begin
          // Memory samples write beat 0 on this same edge, so beat 1 goes out next.
          if (write_q) begin
            data_d = wdata_q[int'(next_beat) * BUS_SIZE +: BUS_SIZE];
          end else begin
            rdata_d[BUS_SIZE-1:0] = mem_data;
          end
          beat_d  = BEAT_W'(1);
          state_d = S_XFER;
        end
`ifdef C2_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          data_oe_d = 1'b0;
          valid_d   = 1'b1;
          error_d   = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_cnt_d = WAIT_W'(wait_cnt_q + 1'b1);
        end
`endif
      end

      S_XFER: begin
        if (write_q) begin
          data_d = wdata_q[int'(next_beat) * BUS_SIZE +: BUS_SIZE];
        end else begin
          rdata_d[int'(beat_q) * BUS_SIZE +: BUS_SIZE] = mem_data;
        end
        beat_d = next_beat;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          data_oe_d = 1'b0;
          valid_d   = 1'b1;
`ifdef C2_TIMEOUT_EN
          error_d   = 1'b0;
`endif
          state_d   = S_DONE;
        end
      end

      // One cycle with req_ready low guarantees a turnaround gap before the next issue.
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        ready_d   = 1'b1;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_c2_line_master.sv
// Self-checking bench for c2_line_master against a 5-cycle-response memory model.
// Define C2_TIMEOUT_EN on both RTL and bench to exercise the WAIT timeout.
module tb_c2_line_master;

  localparam int unsigned ADDR_SIZE = 15;
  localparam int unsigned BUS_SIZE  = 16;
  localparam int unsigned CLS       = 16;
  localparam int unsigned RESP_TIME = 5;

  logic                 clk   = 1'b0;
  logic                 reset = 1'b0;
  logic [ADDR_SIZE-1:0] mem_address;
  wire  [BUS_SIZE-1:0]  mem_data;
  wire  [1:0]           mem_command;

  c2_line_master_if #(.ADDR_SIZE(ADDR_SIZE), .CACHE_LINE_SIZE(CLS)) req_if ();

  c2_line_master #(
    .ADDR_SIZE(ADDR_SIZE),
    .BUS_SIZE(BUS_SIZE),
    .CACHE_LINE_SIZE(CLS)
`ifdef C2_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_if(req_if),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_command(mem_command)
  );

  always #5 clk = ~clk;

  // Memory responder and a probe driver used to prove the DUT has released mem_data.
  logic          m_cmd_oe  = 1'b0;
  logic [1:0]    m_cmd     = 2'd0;
  logic          m_data_oe = 1'b0;
  logic [15:0]   m_data    = 16'h0;
  logic          probe_oe  = 1'b0;
  logic [15:0]   probe_val = 16'h0;
  logic          mem_noresp = 1'b0;

  assign mem_command = m_cmd_oe  ? m_cmd     : 'z;
  assign mem_data    = m_data_oe ? m_data    : 'z;
  assign mem_data    = probe_oe  ? probe_val : 'z;

  logic [127:0] store [logic [14:0]];

  function automatic logic [127:0] init_line(input logic [14:0] a);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[16*i +: 16] = {a[12:0], 3'(i)};
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input logic [14:0] a);
    return store.exists(a) ? store[a] : init_line(a);
  endfunction

  typedef enum {M_IDLE, M_WAIT, M_XF} m_st_e;
  m_st_e        m_st   = M_IDLE;
  int           m_cnt  = 0;
  int           m_beat = 0;
  logic         m_wr   = 1'b0;
  logic [127:0] m_tmp;

  always @(posedge clk) begin
    if (reset) begin
      m_st      <= M_IDLE;
      m_cmd_oe  <= 1'b0;
      m_data_oe <= 1'b0;
      m_cnt     <= 0;
      m_beat    <= 0;
    end else begin
      case (m_st)
        M_IDLE: if (!mem_noresp && (mem_command == 2'd2 || mem_command == 2'd3)) begin
          m_wr  <= (mem_command == 2'd3);
          m_cnt <= 1;
          m_st  <= M_WAIT;
        end
        M_WAIT: begin
          if (m_cnt == RESP_TIME) begin
            m_cmd    <= 2'd1;
            m_cmd_oe <= 1'b1;
            if (!m_wr) begin
              m_tmp     = mem_line(mem_address);
              m_data    <= m_tmp[15:0];
              m_data_oe <= 1'b1;
            end
            m_beat <= 0;
            m_st   <= M_XF;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: begin
          m_cmd_oe <= 1'b0;
          m_tmp = mem_line(mem_address);
          if (m_wr) begin
            m_tmp[16*m_beat +: 16] = mem_data;
            store[mem_address] = m_tmp;
          end else if (m_beat < 7) begin
            m_data <= m_tmp[16*(m_beat+1) +: 16];
          end
          if (m_beat == 7) begin
            m_data_oe <= 1'b0;
            m_st      <= M_IDLE;
          end
          m_beat <= m_beat + 1;
        end
      endcase
    end
  end

  // Cycle monitors: issue cycles seen on the bus and completion pulses.
  int issue_cnt = 0;
  int resp_cnt  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_command == 2'd2 || mem_command == 2'd3) issue_cnt++;
      if (req_if.resp_valid) resp_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns posedges from accept to resp_valid (-1 on timeout).
  task automatic do_txn(input logic wr, input logic [14:0] a, input logic [127:0] wd,
                        output int lat, output logic [1:0] icmd);
    int guard = 0;
    while (req_if.req_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    req_if.req_valid = 1'b1;
    req_if.req_write = wr;
    req_if.req_addr  = a;
    req_if.req_wdata = wd;
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    icmd = mem_command;
    lat  = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!req_if.resp_valid && lat < 100);
    if (!req_if.resp_valid) lat = -1;
  endtask

  typedef struct {
    logic         wr;
    logic [14:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] L0123 = 128'h091F091E091D091C091B091A09190918;
  localparam logic [127:0] WD7F  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] L0000 = 128'h00070006000500040003000200010000;
  localparam logic [127:0] WD01  = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
  localparam logic [127:0] L1FFF = 128'hFFFFFFFEFFFDFFFCFFFBFFFAFFF9FFF8;
  localparam logic [127:0] X1    = 128'hA1A2A3A4A5A6A7A8B1B2B3B4B5B6B7B8;
  localparam logic [127:0] X2    = 128'hC1C2C3C4C5C6C7C8D1D2D3D4D5D6D7D8;
  localparam logic [127:0] WRST  = 128'h000700060005_00FF_000300020001_0000;

  vec_t         vecs [7];
  logic         bb_wr [3];
  logic [127:0] bb_wd [3];
  int           lat, i0, r0, acc, cyc, guard;
  logic [1:0]   icmd;
  logic         rdy;

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_write = 1'b0;
    req_if.req_addr  = '0;
    req_if.req_wdata = '0;

    vecs[0] = '{1'b0, 15'h0123, 128'h0, L0123};
    vecs[1] = '{1'b1, 15'h7FFF, WD7F,   L0123};
    vecs[2] = '{1'b0, 15'h7FFF, 128'h0, WD7F};
    vecs[3] = '{1'b0, 15'h0000, 128'h0, L0000};
    vecs[4] = '{1'b1, 15'h0001, WD01,   L0000};
    vecs[5] = '{1'b0, 15'h0001, 128'h0, WD01};
    vecs[6] = '{1'b0, 15'h1FFF, 128'h0, L1FFF};

    // Asynchronous reset values, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst req_ready",   128'(req_if.req_ready),  128'(1));
    chk("rst resp_valid",  128'(req_if.resp_valid), 128'(0));
    chk("rst resp_rdata",  req_if.resp_rdata,       128'(0));
    chk("rst mem_address", 128'(mem_address),       128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("post-rst req_ready", 128'(req_if.req_ready), 128'(1));

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, icmd);
      chk($sformatf("v%0d latency", i), 128'(lat), 128'(14));
      chk($sformatf("v%0d issue cmd", i), 128'(icmd), vecs[i].wr ? 128'(3) : 128'(2));
      chk($sformatf("v%0d rdata", i), req_if.resp_rdata, vecs[i].exp);
      chk($sformatf("v%0d addr held", i), 128'(mem_address), 128'(vecs[i].addr));
      chk($sformatf("v%0d ready in done", i), 128'(req_if.req_ready), 128'(0));
      @(posedge clk); #1;
      chk($sformatf("v%0d valid pulse", i), 128'(req_if.resp_valid), 128'(0));
      chk($sformatf("v%0d ready idle", i), 128'(req_if.req_ready), 128'(1));
    end
    chk("dump 7fff", mem_line(15'h7FFF), WD7F);

    // Back-to-back with req_valid held high: one accept every 16 cycles.
    bb_wr[0] = 1'b1; bb_wd[0] = X1;
    bb_wr[1] = 1'b0; bb_wd[1] = 128'h0;
    bb_wr[2] = 1'b1; bb_wd[2] = X2;
    i0 = issue_cnt; r0 = resp_cnt; acc = 0; cyc = 0;
    req_if.req_addr  = 15'h0001;
    req_if.req_write = bb_wr[0];
    req_if.req_wdata = bb_wd[0];
    req_if.req_valid = 1'b1;
    while (acc < 3 && cyc < 200) begin
      rdy = req_if.req_ready;
      @(posedge clk); #1; cyc++;
      if (rdy) begin
        acc++;
        if (acc < 3) begin
          req_if.req_write = bb_wr[acc];
          req_if.req_wdata = bb_wd[acc];
        end else begin
          req_if.req_valid = 1'b0;
        end
      end
    end
    chk("b2b accepts", 128'(acc), 128'(3));
    chk("b2b third accept cycle", 128'(cyc), 128'(33));
    guard = 0;
    while (resp_cnt - r0 < 3 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("b2b responses", 128'(resp_cnt - r0), 128'(3));
    chk("b2b issues", 128'(issue_cnt - i0), 128'(3));
    chk("b2b rdata", req_if.resp_rdata, X1);
    do_txn(1'b0, 15'h0001, 128'h0, lat, icmd);
    chk("b2b final read", req_if.resp_rdata, X2);

    // Request pulsed during WAIT must be ignored.
    @(posedge clk); #1;
    i0 = issue_cnt; r0 = resp_cnt;
    req_if.req_valid = 1'b1; req_if.req_write = 1'b0; req_if.req_addr = 15'h0123;
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_if.req_valid = 1'b1; req_if.req_write = 1'b1; req_if.req_addr = 15'h0055;
    req_if.req_wdata = X1;
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    guard = 0;
    while (!req_if.resp_valid && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("busy issues", 128'(issue_cnt - i0), 128'(1));
    chk("busy responses", 128'(resp_cnt - r0), 128'(1));
    chk("busy rdata", req_if.resp_rdata, L0123);
    chk("busy no write", 128'(store.exists(15'h0055)), 128'(0));

    // Reset while beat 4 of a write is on the bus.
    req_if.req_valid = 1'b1; req_if.req_write = 1'b1; req_if.req_addr = 15'h0200;
    req_if.req_wdata = WRST;
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst-xfer beat4 driven", 128'(mem_data), 128'(16'h00FF));
    reset = 1'b1; probe_val = 16'hFF00; probe_oe = 1'b1;
    #1;
    chk("rst-xfer data released", 128'(mem_data), 128'(16'hFF00));
    chk("rst-xfer cmd idle", 128'(mem_command), 128'(0));
    probe_oe = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    i0 = issue_cnt; r0 = resp_cnt;
    @(posedge clk); #1;
    chk("rst-xfer ready", 128'(req_if.req_ready), 128'(1));
    repeat (20) @(posedge clk);
    #1;
    chk("rst-xfer no resp", 128'(resp_cnt - r0), 128'(0));
    chk("rst-xfer no issue", 128'(issue_cnt - i0), 128'(0));
    do_txn(1'b0, 15'h7FFF, 128'h0, lat, icmd);
    chk("post-rst latency", 128'(lat), 128'(14));
    chk("post-rst rdata", req_if.resp_rdata, WD7F);

`ifdef C2_TIMEOUT_EN
    // Memory never answers: timeout after 8 WAIT cycles.
    @(posedge clk); #1;
    mem_noresp = 1'b1;
    do_txn(1'b1, 15'h0300, WRST, lat, icmd);
    chk("to latency", 128'(lat), 128'(9));
    chk("to resp_error", 128'(req_if.resp_error), 128'(1));
    chk("to rdata unchanged", req_if.resp_rdata, WD7F);
    probe_val = 16'hFF00; probe_oe = 1'b1;
    #1;
    chk("to data released", 128'(mem_data), 128'(16'hFF00));
    probe_oe = 1'b0;
    mem_noresp = 1'b0;
    @(posedge clk); #1;
    do_txn(1'b0, 15'h0123, 128'h0, lat, icmd);
    chk("to recover latency", 128'(lat), 128'(14));
    chk("to recover error", 128'(req_if.resp_error), 128'(0));
    chk("to recover rdata", req_if.resp_rdata, L0123);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
